// File: rtl/ndm_reset_seq.sv
// Reset sequencer downstream of the debug module's ndmreset request:
// asserts peripheral and hart resets, waits for acks, then releases in order.
module ndm_reset_seq #(
    parameter int unsigned NrHarts      = 1,
    parameter int unsigned AssertCycles = 16,
    parameter int unsigned ReleaseGap   = 4,
    parameter int unsigned AckTimeout   = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ndmreset_req_i,
    input  logic               dmactive_i,
    input  logic [NrHarts-1:0] hart_rst_ack_i,
    output logic               periph_rst_o,
    output logic [NrHarts-1:0] hart_rst_o,
    output logic               busy_o,
    output logic               seq_done_o,
    output logic               timeout_o
);

    localparam int unsigned CntMax =
        (AssertCycles > ReleaseGap) ? AssertCycles : ReleaseGap;
    localparam int unsigned CntW  = $clog2(CntMax + 1);
    localparam int unsigned TcntW = $clog2(AckTimeout + 1);

    localparam logic [CntW-1:0]  MinLast = CntW'(AssertCycles - 1);
    localparam logic [CntW-1:0]  GapLast = CntW'(ReleaseGap - 1);
    localparam logic [TcntW-1:0] ToLast  = TcntW'(AckTimeout - 1);
    localparam logic [TcntW-1:0] ToSat   = TcntW'(AckTimeout);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] ASSERT     = 2'd1;
    localparam logic [1:0] HOLD       = 2'd2;
    localparam logic [1:0] REL_PERIPH = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [TcntW-1:0] tcnt_q, tcnt_d;
    logic             min_done_q, min_done_d;
    logic             periph_q, periph_d;
    logic             hart_q, hart_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;

    logic req;
    logic acks_ok;
    logic min_done;
    logic to_hit;

    assign req      = ndmreset_req_i & dmactive_i;
    assign acks_ok  = &hart_rst_ack_i;
    assign min_done = min_done_q | (cnt_q == MinLast);
    // A timeout reached in the same cycle already permits the exit
    assign to_hit   = timeout_q | (tcnt_q == ToLast);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tcnt_d     = tcnt_q;
        min_done_d = min_done_q;
        periph_d   = periph_q;
        hart_d     = hart_q;
        done_d     = 1'b0;
        timeout_d  = timeout_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d    = ASSERT;
                    cnt_d      = '0;
                    tcnt_d     = '0;
                    min_done_d = 1'b0;
                    periph_d   = 1'b1;
                    hart_d     = 1'b1;
                    timeout_d  = 1'b0;
                end
            end
            ASSERT: begin
                cnt_d      = min_done ? cnt_q : cnt_q + CntW'(1);
                min_done_d = min_done;
                tcnt_d     = (tcnt_q == ToSat) ? tcnt_q : tcnt_q + TcntW'(1);
                timeout_d  = to_hit;
                if (min_done && (acks_ok || to_hit)) begin
                    cnt_d = '0;
                    if (req) begin
                        state_d = HOLD;
                    end else begin
                        state_d  = REL_PERIPH;
                        periph_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (!req) begin
                    state_d  = REL_PERIPH;
                    cnt_d    = '0;
                    periph_d = 1'b0;
                end
            end
            REL_PERIPH: begin
                // A re-request beats a release landing in the same cycle
                if (req) begin
                    state_d    = ASSERT;
                    cnt_d      = '0;
                    tcnt_d     = '0;
                    min_done_d = 1'b0;
                    periph_d   = 1'b1;
                end else if (cnt_q == GapLast) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    hart_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tcnt_q     <= '0;
            min_done_q <= 1'b0;
            periph_q   <= 1'b0;
            hart_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tcnt_q     <= tcnt_d;
            min_done_q <= min_done_d;
            periph_q   <= periph_d;
            hart_q     <= hart_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign periph_rst_o = periph_q;
    assign hart_rst_o   = {NrHarts{hart_q}};
    assign busy_o       = (state_q != IDLE);
    assign seq_done_o   = done_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_ndm_reset_seq.sv
// Scoreboard bench for ndm_reset_seq: sequence timings predicted from
// request/ack scenarios and checked on each seq_done_o pulse.
module tb_ndm_reset_seq;

    localparam int NH = 2;
    localparam int AC = 16;
    localparam int RG = 4;
    localparam int AT = 64;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          ndmreset_req_i;
    logic          dmactive_i;
    logic [NH-1:0] hart_rst_ack_i;
    logic          periph_rst_o;
    logic [NH-1:0] hart_rst_o;
    logic          busy_o;
    logic          seq_done_o;
    logic          timeout_o;

    ndm_reset_seq #(
        .NrHarts(NH),
        .AssertCycles(AC),
        .ReleaseGap(RG),
        .AckTimeout(AT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .ndmreset_req_i(ndmreset_req_i),
        .dmactive_i(dmactive_i),
        .hart_rst_ack_i(hart_rst_ack_i),
        .periph_rst_o(periph_rst_o),
        .hart_rst_o(hart_rst_o),
        .busy_o(busy_o),
        .seq_done_o(seq_done_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fall;
        int done;
        bit to;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   last_fall = -1;
    logic prev_p = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d",
                     name, cyc, act, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Monitor: pops one expectation per completed sequence
    always @(negedge clk) begin
        exp_t e;
        if (prev_p && !periph_rst_o) last_fall = cyc;
        prev_p = periph_rst_o;
        if (seq_done_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("periph_fall_cycle", last_fall, e.fall);
                chk("done_cycle", cyc, e.done);
                chk("hart_released", hart_rst_o, 0);
                chk("busy_after_done", busy_o, 0);
                chk("timeout_at_done", timeout_o, e.to);
            end
        end
    end

    // L: request length, A: cycle all acks present, A0: early ack bits,
    // rr: re-request this many cycles into peripheral release (-1: none)
    task automatic run_seq(input int L, input int A, input int A0,
                           input int rr, input bit use_dm);
        int   s, x, f, d, k;
        bit   held_ok, r;
        exp_t e;
        s = cyc + 1;
        if (rr >= 0) begin
            f = s + AC + rr + AC;
        end else begin
            x = s + imax(AC, imin(A, AT));
            f = imax(x, s + L);
        end
        d = f + RG;
        e.fall = f;
        e.done = d;
        e.to   = (rr < 0) && (A >= AT);
        exp_q.push_back(e);
        held_ok = 1'b1;
        k = 0;
        forever begin
            r = (k < L) || (rr >= 0 && k == AC + rr);
            if (use_dm) begin
                ndmreset_req_i = 1'b1;
                dmactive_i     = r;
            end else begin
                ndmreset_req_i = r;
                dmactive_i     = 1'b1;
            end
            for (int i = 0; i < NH; i++)
                hart_rst_ack_i[i] = (k >= ((i == NH - 1) ? A : A0));
            @(negedge clk);
            if (k == 0) begin
                chk("assert_periph", periph_rst_o, 1);
                chk("assert_hart", hart_rst_o, {NH{1'b1}});
                chk("assert_busy", busy_o, 1);
                chk("timeout_cleared", timeout_o, 0);
            end
            if (rr >= 0 && k == AC)
                chk("rereq_first_fall", periph_rst_o, 0);
            if (rr >= 0 && k == AC + rr)
                chk("rereq_periph_on", periph_rst_o, 1);
            if (cyc < d && hart_rst_o !== {NH{1'b1}}) held_ok = 1'b0;
            if (cyc >= d) break;
            if (k > 400) begin
                chk("seq_bound", cyc, d);
                break;
            end
            k++;
        end
        chk("hart_held", held_ok, 1);
    endtask

    initial begin
        int L, A, A0, sel, gap;
        bit dm, ok;
        rst_i          = 1'b1;
        ndmreset_req_i = 1'b0;
        dmactive_i     = 1'b0;
        hart_rst_ack_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_periph", periph_rst_o, 0);
        chk("rst_hart", hart_rst_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", seq_done_o, 0);
        chk("rst_timeout", timeout_o, 0);
        rst_i = 1'b0;
        @(negedge clk);

        run_seq(1, 0, 0, -1, 1'b0);
        run_seq(40, 0, 0, -1, 1'b0);
        run_seq(1, 30, 10, -1, 1'b0);
        run_seq(1, 100000, 5, -1, 1'b0);
        ndmreset_req_i = 1'b0;
        hart_rst_ack_i = '0;
        repeat (3) @(negedge clk);
        chk("timeout_sticky", timeout_o, 1);
        run_seq(1, 0, 0, -1, 1'b0);
        run_seq(1, 0, 0, 2, 1'b0);
        run_seq(1, 0, 0, RG, 1'b0);

        for (int n = 0; n < 25; n++) begin
            L   = $urandom_range(1, 40);
            sel = $urandom_range(0, 3);
            case (sel)
                0: A = 0;
                1: A = $urandom_range(1, AC);
                2: A = $urandom_range(AC + 1, AT - 1);
                default: A = $urandom_range(AT, AT + 30);
            endcase
            A0  = $urandom_range(0, A);
            dm  = 1'($urandom_range(0, 1));
            run_seq(L, A, A0, -1, dm);
            ndmreset_req_i = 1'b0;
            dmactive_i     = 1'b1;
            hart_rst_ack_i = NH'($urandom);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end

        ndmreset_req_i = 1'b1;
        dmactive_i     = 1'b0;
        ok = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (busy_o || periph_rst_o || hart_rst_o != 0) ok = 1'b0;
        end
        chk("no_req_without_dmactive", ok, 1);

        dmactive_i     = 1'b1;
        hart_rst_ack_i = '1;
        repeat (25) @(negedge clk);
        chk("hold_busy", busy_o, 1);
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_hold_periph", periph_rst_o, 0);
        chk("rst_hold_hart", hart_rst_o, 0);
        chk("rst_hold_busy", busy_o, 0);
        rst_i          = 1'b0;
        ndmreset_req_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
